// File: rtl/dram_axil_arbiter.sv
// Shares one AXI4-Lite master between num_req_p requesters, one transaction at a time; accept->v_o is 3 cycles with a zero-wait slave.
// Requests are held off (ready_and_o=0) until the response is taken; DRAM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module dram_axil_arbiter #(
  parameter int num_req_p    = 2,
  parameter int data_width_p = 32,
  parameter int addr_width_p = 32
) (
  input  logic                                       aclk,
  input  logic                                       aresetn,

  input  logic [num_req_p-1:0]                       v_i,
  input  logic [num_req_p-1:0]                       w_i,
  input  logic [num_req_p-1:0][addr_width_p-1:0]     addr_i,
  input  logic [num_req_p-1:0][data_width_p-1:0]     data_i,
  input  logic [num_req_p-1:0][data_width_p/8-1:0]   wmask_i,
  output logic [num_req_p-1:0]                       ready_and_o,

  output logic [data_width_p-1:0]                    data_o,
  output logic                                       err_o,
  output logic [num_req_p-1:0]                       v_o,
  input  logic [num_req_p-1:0]                       ready_and_i,

  output logic [addr_width_p-1:0]                    m_axil_awaddr_o,
  output logic [2:0]                                 m_axil_awprot_o,
  output logic                                       m_axil_awvalid_o,
  input  logic                                       m_axil_awready_i,

  output logic [data_width_p-1:0]                    m_axil_wdata_o,
  output logic [data_width_p/8-1:0]                  m_axil_wstrb_o,
  output logic                                       m_axil_wvalid_o,
  input  logic                                       m_axil_wready_i,

  input  logic [1:0]                                 m_axil_bresp_i,
  input  logic                                       m_axil_bvalid_i,
  output logic                                       m_axil_bready_o,

  output logic [addr_width_p-1:0]                    m_axil_araddr_o,
  output logic [2:0]                                 m_axil_arprot_o,
  output logic                                       m_axil_arvalid_o,
  input  logic                                       m_axil_arready_i,

  input  logic [data_width_p-1:0]                    m_axil_rdata_i,
  input  logic [1:0]                                 m_axil_rresp_i,
  input  logic                                       m_axil_rvalid_i,
  output logic                                       m_axil_rready_o
);

  localparam int IdxW  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int CandW = IdxW + 1;
  localparam int MaskW = data_width_p / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WRESP,
    S_READ,
    S_RRESP,
    S_DELIVER
  } state_e;

  state_e                   state_q, state_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [addr_width_p-1:0]  addr_q, addr_d;
  logic [data_width_p-1:0]  wdata_q, wdata_d;
  logic [MaskW-1:0]         wmask_q, wmask_d;
  logic                     aw_done_q, aw_done_d;
  logic                     w_done_q, w_done_d;
  logic [data_width_p-1:0]  data_q, data_d;
  logic                     err_q, err_d;

  logic [num_req_p-1:0]     grant;
  logic [IdxW-1:0]          grant_idx;
  logic                     accept;

`ifdef DRAM_ARB_FIXED_PRIO_EN
  // Scan high to low so the lowest asserted index is the one left standing.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      if (v_i[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IdxW'(i);
      end
    end
  end
`else
  logic [IdxW-1:0] rr_q, rr_d;

  always_comb begin
    logic             found;
    logic [CandW-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < num_req_p; i++) begin
      cand = {1'b0, rr_q} + CandW'(i);
      if (cand >= CandW'(num_req_p)) begin
        cand = cand - CandW'(num_req_p);
      end
      if (!found && v_i[cand[IdxW-1:0]]) begin
        found                  = 1'b1;
        grant[cand[IdxW-1:0]]  = 1'b1;
        grant_idx              = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (accept) begin
      rr_d = (grant_idx == IdxW'(num_req_p - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  assign accept      = (state_q == S_IDLE) && (|grant);
  assign ready_and_o = (state_q == S_IDLE) ? grant : '0;

  // Holding registers drive the channels directly, so addr/data stay stable while valid.
  assign m_axil_awaddr_o = addr_q;
  assign m_axil_araddr_o = addr_q;
  assign m_axil_wdata_o  = wdata_q;
  assign m_axil_wstrb_o  = wmask_q;
  assign m_axil_awprot_o = 3'b000;
  assign m_axil_arprot_o = 3'b000;
  assign data_o          = data_q;
  assign err_o           = err_q;

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    wmask_d          = wmask_q;
    aw_done_d        = aw_done_q;
    w_done_d         = w_done_q;
    data_d           = data_q;
    err_d            = err_q;
    m_axil_awvalid_o = 1'b0;
    m_axil_wvalid_o  = 1'b0;
    m_axil_bready_o  = 1'b0;
    m_axil_arvalid_o = 1'b0;
    m_axil_rready_o  = 1'b0;
    v_o              = '0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          idx_d     = grant_idx;
          addr_d    = addr_i[grant_idx];
          wdata_d   = data_i[grant_idx];
          wmask_d   = wmask_i[grant_idx];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = w_i[grant_idx] ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        m_axil_awvalid_o = !aw_done_q;
        m_axil_wvalid_o  = !w_done_q;
        if (!aw_done_q && m_axil_awready_i) aw_done_d = 1'b1;
        if (!w_done_q && m_axil_wready_i)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = S_WRESP;
      end
      S_WRESP: begin
        m_axil_bready_o = 1'b1;
        if (m_axil_bvalid_i) begin
          data_d  = '0;
          err_d   = |m_axil_bresp_i;
          state_d = S_DELIVER;
        end
      end
      S_READ: begin
        m_axil_arvalid_o = 1'b1;
        if (m_axil_arready_i) state_d = S_RRESP;
      end
      S_RRESP: begin
        m_axil_rready_o = 1'b1;
        if (m_axil_rvalid_i) begin
          data_d  = m_axil_rdata_i;
          err_d   = |m_axil_rresp_i;
          state_d = S_DELIVER;
        end
      end
      S_DELIVER: begin
        v_o[idx_q] = 1'b1;
        if (ready_and_i[idx_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      idx_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_dram_axil_arbiter.sv
// Directed bench for dram_axil_arbiter: AXI-Lite slave model with configurable stalls, response scoreboard queue.
module tb_dram_axil_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam logic [31:0] RKEY = 32'hA5A5_0000;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic [N-1:0]             v_i, w_i, ready_and_o, v_o, ready_and_i;
  logic [N-1:0][AW-1:0]     addr_i;
  logic [N-1:0][DW-1:0]     data_i;
  logic [N-1:0][DW/8-1:0]   wmask_i;
  logic [DW-1:0]            data_o;
  logic                     err_o;

  logic [AW-1:0]   awaddr, araddr;
  logic [2:0]      awprot, arprot;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]      bresp, rresp;

  dram_axil_arbiter #(.num_req_p(N), .data_width_p(DW), .addr_width_p(AW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .v_i(v_i), .w_i(w_i), .addr_i(addr_i), .data_i(data_i), .wmask_i(wmask_i),
    .ready_and_o(ready_and_o), .data_o(data_o), .err_o(err_o), .v_o(v_o),
    .ready_and_i(ready_and_i),
    .m_axil_awaddr_o(awaddr), .m_axil_awprot_o(awprot), .m_axil_awvalid_o(awvalid),
    .m_axil_awready_i(awready),
    .m_axil_wdata_o(wdata), .m_axil_wstrb_o(wstrb), .m_axil_wvalid_o(wvalid),
    .m_axil_wready_i(wready),
    .m_axil_bresp_i(bresp), .m_axil_bvalid_i(bvalid), .m_axil_bready_o(bready),
    .m_axil_araddr_o(araddr), .m_axil_arprot_o(arprot), .m_axil_arvalid_o(arvalid),
    .m_axil_arready_i(arready),
    .m_axil_rdata_i(rdata), .m_axil_rresp_i(rresp), .m_axil_rvalid_i(rvalid),
    .m_axil_rready_o(rready)
  );

  // Slave model
  int          aw_delay = 0, w_delay = 0;
  bit          b_hold = 1'b0, rdata_from_addr = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;
  int          aw_cnt = 0, w_cnt = 0;
  int          aw_hs_cnt = 0, w_hs_cnt = 0;
  bit          aw_got = 1'b0, w_got = 1'b0;

  assign awready = awvalid && (aw_cnt >= aw_delay);
  assign wready  = wvalid && (w_cnt >= w_delay);
  assign arready = 1'b1;

  always @(posedge aclk) begin
    if (!aresetn) begin
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
    end else begin
      if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
      else if (awvalid)        aw_cnt <= 0;
      if (wvalid && !wready)   w_cnt <= w_cnt + 1;
      else if (wvalid)         w_cnt <= 0;
      if (awvalid && awready)  aw_hs_cnt <= aw_hs_cnt + 1;
      if (wvalid && wready)    w_hs_cnt <= w_hs_cnt + 1;

      if (bvalid) begin
        if (bready) bvalid <= 1'b0;
      end else if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && !b_hold) begin
        bvalid <= 1'b1; bresp <= bresp_cfg; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (awvalid && awready) aw_got <= 1'b1;
        if (wvalid && wready)   w_got  <= 1'b1;
      end

      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= rdata_from_addr ? (araddr ^ RKEY) : rdata_cfg;
        rresp  <= rresp_cfg;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  typedef struct {
    logic [N-1:0]  v;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input logic [N-1:0] v, input logic [DW-1:0] d, input logic e);
    exp_t x;
    x.v = v; x.data = d; x.err = e;
    sb.push_back(x);
  endtask

  // Waits (bounded) for a grant within mask, takes the accept edge, then drops v_i bits in drop.
  task automatic accept(input string tag, input logic [N-1:0] mask, input logic [N-1:0] drop);
    int n;
    n = 0;
    #1;
    while (((ready_and_o & mask) == '0) && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_grant_onehot"}, 64'($onehot(ready_and_o & mask)), 64'd1);
    tick();
    v_i = v_i & ~drop;
  endtask

  // Called in the cycle after accept (start=1); compares the response against the scoreboard head.
  task automatic wait_resp(input string tag, input int start, input int exp_lat);
    int   cyc;
    exp_t e;
    cyc = start;
    while (v_o == '0 && cyc < start + 40) begin
      tick();
      cyc++;
    end
    chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_v_o"}, 64'(v_o), 64'(e.v));
      chk({tag, "_data_o"}, 64'(data_o), 64'(e.data));
      chk({tag, "_err_o"}, 64'(err_o), 64'(e.err));
      if (exp_lat > 0) chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    end
  endtask

  initial begin
    int awn0, wn0, g;
    aresetn = 1'b0; v_i = '0; w_i = '0; addr_i = '0; data_i = '0; wmask_i = '0;
    ready_and_i = '1;
    repeat (2) tick();

    chk("rst_axi_valids", 64'({awvalid, wvalid, arvalid}), 64'd0);
    chk("rst_b_r_ready", 64'({bready, rready}), 64'd0);
    chk("rst_v_o", 64'(v_o), 64'd0);
    chk("rst_data_o", 64'(data_o), 64'd0);
    chk("rst_err_o", 64'(err_o), 64'd0);
    chk("rst_prot", 64'({awprot, arprot}), 64'd0);
    aresetn = 1'b1;
    tick();

    // Single read, zero-wait slave
    rdata_from_addr = 1'b0; rdata_cfg = 32'h1234_5678;
    v_i[0] = 1'b1; w_i[0] = 1'b0; addr_i[0] = 32'h40;
    push(2'b01, 32'h1234_5678, 1'b0);
    accept("rd", 2'b01, 2'b01);
    chk("rd_arvalid", 64'(arvalid), 64'd1);
    chk("rd_araddr", 64'(araddr), 64'h40);
    wait_resp("rd", 1, 3);
    tick();

    // Write, W accepted before AW
    aw_delay = 3; awn0 = aw_hs_cnt; wn0 = w_hs_cnt;
    v_i[1] = 1'b1; w_i[1] = 1'b1; addr_i[1] = 32'h80; data_i[1] = 32'hCAFE_F00D; wmask_i[1] = 4'hF;
    push(2'b10, 32'h0, 1'b0);
    accept("wr", 2'b10, 2'b10);
    chk("wr_c1_valids", 64'({awvalid, wvalid}), 64'b11);
    chk("wr_awaddr", 64'(awaddr), 64'h80);
    chk("wr_wdata", 64'(wdata), 64'hCAFE_F00D);
    chk("wr_wstrb", 64'(wstrb), 64'hF);
    tick();
    chk("wr_c2_valids", 64'({awvalid, wvalid}), 64'b10);
    wait_resp("wr", 2, 6);
    tick();
    chk("wr_aw_hs_count", 64'(aw_hs_cnt - awn0), 64'd1);
    chk("wr_w_hs_count", 64'(w_hs_cnt - wn0), 64'd1);
    aw_delay = 0; w_i = '0;

    // Contention: both requesters hold v_i across 4 transactions
    rdata_from_addr = 1'b1;
    addr_i[0] = 32'h100; addr_i[1] = 32'h200;
    for (int k = 0; k < 4; k++) begin
`ifdef DRAM_ARB_FIXED_PRIO_EN
      g = 0;
`else
      g = k % 2;
`endif
      push(2'(1 << g), (g == 0 ? 32'h100 : 32'h200) ^ RKEY, 1'b0);
    end
    v_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      accept("cont", 2'b11, (k == 3) ? 2'b11 : 2'b00);
      wait_resp("cont", 1, 3);
      tick();
    end

    // Backpressure in DELIVER; the other requester's ready must not release it
    ready_and_i = 2'b10;
    addr_i[0] = 32'h44; v_i = 2'b01;
    push(2'b01, 32'h44 ^ RKEY, 1'b0);
    accept("bp", 2'b01, 2'b01);
    addr_i[1] = 32'h88; v_i[1] = 1'b1;
    push(2'b10, 32'h88 ^ RKEY, 1'b0);
    wait_resp("bp", 1, 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_v_o", 64'(v_o), 64'b01);
      chk("bp_data_o", 64'(data_o), 64'(32'h44 ^ RKEY));
      chk("bp_ready_and_o", 64'(ready_and_o), 64'd0);
      chk("bp_axi_valids", 64'({awvalid, wvalid, arvalid}), 64'd0);
    end
    ready_and_i = 2'b11;
    tick();
    accept("bp2", 2'b10, 2'b10);
    wait_resp("bp2", 1, 3);
    tick();

    // Error response
    rresp_cfg = 2'b10;
    addr_i[1] = 32'h90; v_i[1] = 1'b1;
    push(2'b10, 32'h90 ^ RKEY, 1'b1);
    accept("err", 2'b10, 2'b10);
    wait_resp("err", 1, 3);
    tick();
    rresp_cfg = 2'b00;

    // Reset mid-WRESP, then a fresh pair of reads must start from requester 0
    b_hold = 1'b1;
    v_i[0] = 1'b1; w_i[0] = 1'b1; addr_i[0] = 32'hC0; data_i[0] = 32'h5555; wmask_i[0] = 4'h3;
    accept("rstw", 2'b01, 2'b01);
    tick();
    chk("rstw_bready", 64'(bready), 64'd1);
    v_i = 2'b11;
    #1;
    chk("rstw_busy_rdy", 64'(ready_and_o), 64'd0);
    v_i = 2'b00;
    aresetn = 1'b0;
    tick();
    chk("rstw_axi_valids", 64'({awvalid, wvalid, arvalid}), 64'd0);
    chk("rstw_b_r_ready", 64'({bready, rready}), 64'd0);
    chk("rstw_v_o", 64'(v_o), 64'd0);
    chk("rstw_data_o", 64'(data_o), 64'd0);
    chk("rstw_err_o", 64'(err_o), 64'd0);
    aresetn = 1'b1; b_hold = 1'b0;
    w_i = '0; addr_i[0] = 32'h48; addr_i[1] = 32'h4C;
    push(2'b01, 32'h48 ^ RKEY, 1'b0);
    push(2'b10, 32'h4C ^ RKEY, 1'b0);
    v_i = 2'b11;
    accept("post_rst0", 2'b11, 2'b01);
    wait_resp("post_rst0", 1, 3);
    tick();
    accept("post_rst1", 2'b10, 2'b10);
    wait_resp("post_rst1", 1, 3);
    tick();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
